uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter: the byte-stream companion to the existing uart_rx receive path.
- Accepts bytes over a valid/ready handshake into an internal FIFO, then serializes them on o_tx (LSB first), back-to-back with no idle gap.
- Sits between a byte producer (command/response logic) and the board TX pin, replacing single-shot send control.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART frame constants and serializer state encoding,
//               common to the transmit and receive paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count; push when full and
//               pop when empty are silently ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;

   // Pointers wrap on their own since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_data;
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_count = count_q;
   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered 8N1 UART transmitter; bytes queue in a FIFO and are
//               serialized LSB first with no idle gap between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int BAUD_RATE  = 115200,
   parameter int CLK_FREQ   = 300000000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [7:0]                    i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic                          o_tx,
   output logic                          o_active,
   output logic                          o_tx_hs,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_fifo_full,
   output logic                          o_fifo_empty
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W        = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

   uart_state_e      state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              avail_q;
   logic              baud_last;
   logic              fifo_pop;
   logic [7:0]        fifo_head;
   logic              fifo_full;
   logic              fifo_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_valid),
      .i_data  (i_data),
      .i_pop   (fifo_pop),
      .o_data  (fifo_head),
      .o_count (o_fifo_count),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   assign baud_last    = (baud_q == BAUD_LAST);
   assign o_ready      = !fifo_full;
   assign o_fifo_full  = fifo_full;
   assign o_fifo_empty = fifo_empty;
   assign o_active     = (state_q != ST_IDLE);

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q + BAUD_W'(1);
      idx_d    = idx_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      o_tx     = 1'b1;
      o_tx_hs  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            // Starting from idle waits for the head to have settled a cycle.
            if (avail_q && !fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_head;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            o_tx = 1'b0;
            if (baud_last) begin
               baud_d  = '0;
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            o_tx = shift_q[idx_q];
            if (baud_last) begin
               baud_d = '0;
               if (idx_q == IDX_LAST) state_d = ST_STOP;
               else                   idx_d   = idx_q + IDX_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_last) begin
               o_tx_hs = 1'b1;
               baud_d  = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_head;
                  state_d  = ST_START;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         avail_q <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         avail_q <= !fifo_empty;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo against a queue-based
//               model of the byte stream and the 8N1 line waveform.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   localparam int CLK_FREQ   = 1000;
   localparam int BAUD_RATE  = 100;
   localparam int FIFO_DEPTH = 4;
   localparam int CPB        = CLK_FREQ / BAUD_RATE;
   localparam int FRAME      = 10 * CPB;
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    data = 8'h00;
   logic          valid = 1'b0;
   logic          ready, tx, active, tx_hs, full, empty;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .BAUD_RATE  (BAUD_RATE),
      .CLK_FREQ   (CLK_FREQ),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_data       (data),
      .i_valid      (valid),
      .o_ready      (ready),
      .o_tx         (tx),
      .o_active     (active),
      .o_tx_hs      (tx_hs),
      .o_fifo_count (count),
      .o_fifo_full  (full),
      .o_fifo_empty (empty)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected line level for frame slot 0 (start), 1..8 (data LSB first), 9 (stop).
   function automatic logic line_bit(input logic [7:0] b, input int slot);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   // Reference model: stored bytes as a queue, line tracked per frame.
   logic [7:0] sent_q[$];
   logic [7:0] cur_byte;
   logic       pv;
   logic [7:0] pd;
   bit         in_frame, exp_start, avail_prev, start_now, was_full;
   int         fcnt;

   always @(posedge clk) begin
      pv <= valid & rst_n;
      pd <= data;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         sent_q.delete();
         in_frame   = 0;
         exp_start  = 0;
         avail_prev = 0;
         fcnt       = 0;
      end else begin
         was_full = (sent_q.size() >= FIFO_DEPTH);
         if (in_frame) begin
            fcnt++;
            if (fcnt == FRAME) in_frame = 0;
         end
         start_now = !in_frame && (tx === 1'b0);
         check("frame_start", start_now, exp_start);
         if (start_now) begin
            check("pop_nonempty", sent_q.size() > 0, 1);
            if (sent_q.size() > 0) cur_byte = sent_q.pop_front();
            in_frame = 1;
            fcnt     = 0;
         end
         if (pv && !was_full) sent_q.push_back(pd);
         check("count", count, sent_q.size());
         check("full", full, sent_q.size() == FIFO_DEPTH);
         check("empty", empty, sent_q.size() == 0);
         check("ready", ready, sent_q.size() < FIFO_DEPTH);
         check("active", active, in_frame);
         check("tx_hs", tx_hs, in_frame && (fcnt == FRAME - 1));
         if (in_frame) check("line", tx, line_bit(cur_byte, fcnt / CPB));
         if (in_frame) exp_start = (fcnt == FRAME - 1) && (sent_q.size() > 0);
         else          exp_start = (sent_q.size() > 0) && avail_prev;
         avail_prev = (sent_q.size() > 0);
      end
   end

   task automatic drive(input logic v, input logic [7:0] d);
      @(negedge clk);
      #1;
      valid = v;
      data  = d;
   endtask

   task automatic push_hs(input logic [7:0] b);
      bit acc;
      acc = 0;
      drive(1'b1, b);
      for (int i = 0; i < 2000 && !acc; i++) begin
         acc = ready;
         @(posedge clk);
         if (!acc) begin
            @(negedge clk);
            #1;
         end
      end
      check("push_timeout", acc, 1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         #2;
         done = empty && !active;
      end
      check("drain_timeout", done, 1);
   endtask

   initial begin
      #12;
      check("rst_tx", tx, 1);
      check("rst_active", active, 0);
      check("rst_hs", tx_hs, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ready", ready, 1);
      @(negedge clk);
      #3;
      rst_n = 1'b1;
      repeat (3) drive(1'b0, 8'h00);

      // Single byte latency: pushed at edge N, line falls after edge N+2.
      drive(1'b1, 8'hA5);
      @(posedge clk);
      drive(1'b0, 8'h00);
      @(posedge clk);
      #1;
      check("lat_n1", tx, 1);
      @(posedge clk);
      #1;
      check("lat_n2", tx, 0);
      wait_idle();

      // Three back-to-back frames.
      drive(1'b1, 8'h01);
      drive(1'b1, 8'h02);
      drive(1'b1, 8'h03);
      drive(1'b0, 8'h00);
      wait_idle();

      // Overfill: 0x15 arrives while full and is dropped.
      for (int i = 0; i < 6; i++) drive(1'b1, 8'h10 + 8'(i));
      drive(1'b0, 8'h00);
      check("fill_count", count, 4);
      check("fill_ready", ready, 0);
      begin
         bit back;
         back = 0;
         for (int i = 0; i < 300 && !back; i++) begin
            @(negedge clk);
            #1;
            back = ready;
         end
         check("ready_return", back, 1);
         check("ready_return_count", count, 3);
      end
      wait_idle();

      // Extreme data values.
      drive(1'b1, 8'hFF);
      drive(1'b1, 8'h00);
      drive(1'b0, 8'h00);
      wait_idle();

      // Continuous stream through the pointer wrap.
      for (int i = 0; i < 20; i++) push_hs(8'($urandom));
      drive(1'b0, 8'h00);
      wait_idle();

      // Reset in the middle of a data bit with two bytes queued.
      drive(1'b1, 8'h3C);
      drive(1'b1, 8'h11);
      drive(1'b1, 8'h22);
      drive(1'b0, 8'h00);
      repeat (45) @(negedge clk);
      check("pre_rst_count", count, 2);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_active", active, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_ready", ready, 1);
      @(negedge clk);
      #3;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      check("post_rst_idle", tx, 1);
      check("post_rst_active", active, 0);

      // Random traffic, ignoring ready so full-drop behaviour is exercised.
      for (int i = 0; i < 1500; i++)
         drive($urandom_range(0, 9) < 3, 8'($urandom));
      drive(1'b0, 8'h00);
      wait_idle();
      check("leftover", sent_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
